// File: rtl/seg7_pkg.sv
// 7-segment capture shared types: glyph table, FSM states, decoder.
package seg7_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-high {a..g} glyphs, indexed by hex value.
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,
    7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F,
    7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic {
    S_IDLE,
    S_TRACK
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] value;
  } dec_t;

  function automatic dec_t seg7_dec(
    input logic [SEG_W-1:0] pat
  );
    dec_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (pat == GLYPH[i]) begin
        r.legal = 1'b1;
        r.value = 4'(i);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/seg7_stab_filter.sv
// Segment sampler and stability counter; strobes once when a
// freshly sampled pattern has been held for STABLE_CYC samples.
module seg7_stab_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg_in,
  output logic [SEG_W-1:0] seg_q,
  output logic             stable
);
  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [SEG_W-1:0] seg_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  always_comb begin
    seg_d = seg_in;
    cnt_d = cnt_q;
    if (seg_in != seg_q) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(STABLE_CYC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= SEG_BLANK;
      cnt_q <= '0;
    end else begin
      seg_q <= seg_d;
      cnt_q <= cnt_d;
    end
  end

  assign stable = (cnt_q == CW'(STABLE_CYC - 1));
endmodule

// File: rtl/seg7_capture.sv
// 7-segment bus monitor: debounce, decode, sequence check, error count.
// Define SEG7_BLANK_EN to accept the all-off pattern as a legal blank.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int MOD        = 16,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg_in,
  output logic [3:0]       digit,
  output logic             digit_vld,
  output logic             illegal,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             tracking
);
  logic [SEG_W-1:0] seg_q;
  logic             stable;
  logic             acc;
  logic             blank;
  dec_t             dec;
  logic [3:0]       exp_nxt;

  logic [SEG_W-1:0] last_q, last_d;
  state_t           state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       digit_q, digit_d;
  logic             vld_q, vld_d;
  logic             ill_q, ill_d;
  logic             seq_q, seq_d;
  logic [ERR_W-1:0] err_q, err_d;

  seg7_stab_filter #(
    .STABLE_CYC(STABLE_CYC)
  ) u_filt (
    .clk   (clk),
    .rst   (rst),
    .seg_in(seg_in),
    .seg_q (seg_q),
    .stable(stable)
  );

  assign acc     = stable && (seg_q != last_q);
  assign dec     = seg7_dec(~seg_q);
  assign exp_nxt = 4'((32'(prev_q) + 32'd1) % MOD);

`ifdef SEG7_BLANK_EN
  assign blank = (seg_q == SEG_BLANK);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    last_d  = last_q;
    state_d = state_q;
    prev_d  = prev_q;
    digit_d = digit_q;
    vld_d   = 1'b0;
    ill_d   = 1'b0;
    seq_d   = 1'b0;
    err_d   = err_q;
    if (acc) begin
      last_d = seg_q;
      vld_d  = 1'b1;
      unique case (1'b1)
        blank: begin
          state_d = S_IDLE;
        end
        !blank && !dec.legal: begin
          ill_d   = 1'b1;
          state_d = S_IDLE;
        end
        !blank && dec.legal: begin
          digit_d = dec.value;
          prev_d  = dec.value;
          state_d = S_TRACK;
          // Mismatch resyncs to the new digit rather than dropping out.
          if (state_q == S_TRACK && dec.value != exp_nxt) begin
            seq_d = 1'b1;
          end
        end
        default: ;
      endcase
      if ((ill_d || seq_d) && err_q != '1) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= SEG_BLANK;
      state_q <= S_IDLE;
      prev_q  <= '0;
      digit_q <= '0;
      vld_q   <= 1'b0;
      ill_q   <= 1'b0;
      seq_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      last_q  <= last_d;
      state_q <= state_d;
      prev_q  <= prev_d;
      digit_q <= digit_d;
      vld_q   <= vld_d;
      ill_q   <= ill_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
    end
  end

  assign digit     = digit_q;
  assign digit_vld = vld_q;
  assign illegal   = ill_q;
  assign seq_err   = seq_q;
  assign err_cnt   = err_q;
  assign tracking  = (state_q == S_TRACK);
endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: run-length reference model plus directed
// and randomized scenarios.
`timescale 1ns/1ps
module tb_seg7_capture;
  localparam int S     = 4;
  localparam int MOD   = 16;
  localparam int ERR_W = 8;
`ifdef SEG7_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       seg_in = 7'h7F;
  logic [3:0]       digit;
  logic             digit_vld;
  logic             illegal;
  logic             seq_err;
  logic [ERR_W-1:0] err_cnt;
  logic             tracking;

  seg7_capture #(
    .STABLE_CYC(S),
    .MOD       (MOD),
    .ERR_W     (ERR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seg_in   (seg_in),
    .digit    (digit),
    .digit_vld(digit_vld),
    .illegal  (illegal),
    .seq_err  (seq_err),
    .err_cnt  (err_cnt),
    .tracking (tracking)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int               cyc;
    logic             vld;
    logic [3:0]       digit;
    logic             ill;
    logic             seq;
    logic [ERR_W-1:0] err;
    logic             trk;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  logic [6:0] tbl [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Reference model: a pattern is accepted once it has been seen on
  // S consecutive edges and differs from the last accepted pattern.
  logic [6:0] run_pat = 7'h7F;
  int         run_len = 0;
  logic [6:0] m_last  = 7'h7F;
  bit         m_trk   = 1'b0;
  int         m_prev  = 0;
  int         m_digit = 0;
  int         m_err   = 0;

  task automatic tick();
    int  v;
    ev_t e;
    ev_t o;
    @(posedge clk);
    cyc++;
    if (seg_in == run_pat) begin
      run_len++;
    end else begin
      run_pat = seg_in;
      run_len = 1;
    end
    if (run_len == S && run_pat != m_last) begin
      m_last = run_pat;
      v = -1;
      for (int i = 0; i < 16; i++)
        if (~run_pat == tbl[i]) v = i;
      e     = '0;
      e.cyc = cyc + 1;
      e.vld = 1'b1;
      if (BLANK_EN && run_pat == 7'h7F) begin
        m_trk = 1'b0;
      end else if (v < 0) begin
        e.ill = 1'b1;
        m_trk = 1'b0;
      end else begin
        if (m_trk && v != (m_prev + 1) % MOD) e.seq = 1'b1;
        m_trk   = 1'b1;
        m_prev  = v;
        m_digit = v;
      end
      if ((e.ill || e.seq) && m_err < (1 << ERR_W) - 1) m_err++;
      e.digit = 4'(m_digit);
      e.err   = ERR_W'(m_err);
      e.trk   = m_trk;
      exp_q.push_back(e);
    end
    #1;
    if (digit_vld || illegal || seq_err) begin
      o.cyc   = cyc;
      o.vld   = digit_vld;
      o.digit = digit;
      o.ill   = illegal;
      o.seq   = seq_err;
      o.err   = err_cnt;
      o.trk   = tracking;
      obs_q.push_back(o);
    end
  endtask

  task automatic drive(input logic [6:0] p, input int h);
    seg_in = p;
    repeat (h) tick();
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst     = 1'b1;
    run_pat = 7'h7F;
    run_len = 0;
    m_last  = 7'h7F;
    m_trk   = 1'b0;
    m_prev  = 0;
    m_digit = 0;
    m_err   = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    #2;
    assert_reset();
    checks++;
    if ({digit, digit_vld, illegal, seq_err, err_cnt, tracking} !== '0)
      begin errors++; $display("FAIL reset_outs got %h want 0",
        {digit, digit_vld, illegal, seq_err, err_cnt, tracking}); end
    release_reset();
    repeat (3) tick();
    checks++;
    if (obs_q.size() != 0 || tracking !== 1'b0)
      begin errors++; $display("FAIL reset_idle got %0d pulses trk %b want 0 0",
        obs_q.size(), tracking); end
  endtask

  task automatic test_count();
    int nseq;
    for (int g = 0; g < 16; g++) drive(~tbl[g], 6);
    repeat (2) tick();
    checks++;
    if (obs_q.size() != exp_q.size())
      begin errors++; $display("FAIL count_sb_size got %0d want %0d",
        obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin errors++; $display("FAIL count_ev%0d got %h want %h",
          i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (obs_q.size() != 16)
      begin errors++; $display("FAIL count_pulses got %0d want 16",
        obs_q.size()); end
    checks++;
    if (obs_q.size() == 0 || obs_q[0].digit !== 4'd0 || obs_q[0].trk !== 1'b1)
      begin errors++; $display("FAIL count_first got %h want digit 0 trk 1",
        obs_q.size() ? obs_q[0] : '0); end
    nseq = 0;
    foreach (obs_q[i]) if (obs_q[i].seq) nseq++;
    checks++;
    if (nseq != 0 || err_cnt !== '0)
      begin errors++; $display("FAIL count_clean got seq %0d err %0d want 0 0",
        nseq, err_cnt); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_seq();
    assert_reset();
    checks++;
    if ({digit, digit_vld, illegal, seq_err, err_cnt, tracking} !== '0)
      begin errors++; $display("FAIL seq_reset got %h want 0",
        {digit, digit_vld, illegal, seq_err, err_cnt, tracking}); end
    release_reset();
    drive(~tbl[3], 6);
    drive(~tbl[4], 6);
    drive(~tbl[6], 6);
    drive(~tbl[7], 6);
    repeat (2) tick();
    checks++;
    if (obs_q.size() != exp_q.size())
      begin errors++; $display("FAIL seq_sb_size got %0d want %0d",
        obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin errors++; $display("FAIL seq_ev%0d got %h want %h",
          i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (obs_q.size() != 4 || obs_q[1].seq !== 1'b0 ||
        obs_q[2].seq !== 1'b1 || obs_q[3].seq !== 1'b0)
      begin errors++; $display("FAIL seq_pulse got n %0d want seq only on 6",
        obs_q.size()); end
    checks++;
    if (err_cnt !== 8'd1 || tracking !== 1'b1)
      begin errors++; $display("FAIL seq_errcnt got %0d trk %b want 1 1",
        err_cnt, tracking); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_bounce();
    drive(~7'h5B, 2);
    drive(~7'h30, 6);
    repeat (2) tick();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].digit !== 4'd1)
      begin errors++; $display("FAIL bounce got n %0d digit %0d want 1 1",
        obs_q.size(), obs_q.size() ? obs_q[0].digit : 4'd0); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin errors++; $display("FAIL bounce_ev%0d got %h want %h",
          i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_illegal();
    drive(~7'h01, 6);
    repeat (2) tick();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].ill !== 1'b1 || obs_q[0].seq !== 1'b0)
      begin errors++; $display("FAIL illegal_pulse got n %0d want 1 ill",
        obs_q.size()); end
    checks++;
    if (digit !== 4'd1 || tracking !== 1'b0 || err_cnt !== 8'd3)
      begin errors++; $display("FAIL illegal_state got d %0d trk %b err %0d want 1 0 3",
        digit, tracking, err_cnt); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin errors++; $display("FAIL illegal_ev%0d got %h want %h",
          i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_blank();
    logic             want_ill;
    logic [ERR_W-1:0] want_err;
    want_ill = BLANK_EN ? 1'b0 : 1'b1;
    want_err = BLANK_EN ? 8'd3 : 8'd4;
    drive(~tbl[2], 6);
    checks++;
    if (tracking !== 1'b1)
      begin errors++; $display("FAIL blank_pre got trk %b want 1", tracking); end
    drive(7'h7F, 6);
    repeat (2) tick();
    checks++;
    if (obs_q.size() != 2 || obs_q[1].ill !== want_ill ||
        obs_q[1].seq !== 1'b0 || obs_q[1].digit !== 4'd2)
      begin errors++; $display("FAIL blank_pulse got n %0d ill %b want 2 %b",
        obs_q.size(), obs_q.size() > 1 ? obs_q[1].ill : 1'b0, want_ill); end
    checks++;
    if (tracking !== 1'b0 || err_cnt !== want_err)
      begin errors++; $display("FAIL blank_state got trk %b err %0d want 0 %0d",
        tracking, err_cnt, want_err); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random();
    logic [6:0] p;
    int         r;
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 3);
      if (r < 2) p = ~tbl[(m_prev + 1) % MOD];
      else if (r == 2) p = ~tbl[$urandom_range(0, 15)];
      else p = 7'($urandom);
      if (p == seg_in) p = p ^ 7'h08;
      drive(p, $urandom_range(1, 7));
    end
    repeat (2) tick();
    checks++;
    if (obs_q.size() != exp_q.size())
      begin errors++; $display("FAIL rand_sb_size got %0d want %0d",
        obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin errors++; $display("FAIL rand_ev%0d got %h want %h",
          i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (err_cnt !== ERR_W'(m_err) || tracking !== m_trk)
      begin errors++; $display("FAIL rand_state got err %0d trk %b want %0d %b",
        err_cnt, tracking, m_err, m_trk); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_saturate();
    int rel;
    assert_reset();
    release_reset();
    for (int i = 0; i < (1 << ERR_W) + 3; i++)
      drive((i % 2) ? ~7'h02 : ~7'h01, S);
    repeat (2) tick();
    checks++;
    if (err_cnt !== '1)
      begin errors++; $display("FAIL sat_errcnt got %0d want %0d",
        err_cnt, (1 << ERR_W) - 1); end
    checks++;
    if (obs_q.size() != (1 << ERR_W) + 3)
      begin errors++; $display("FAIL sat_pulses got %0d want %0d",
        obs_q.size(), (1 << ERR_W) + 3); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin errors++; $display("FAIL sat_ev%0d got %h want %h",
          i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete();
    obs_q.delete();
    drive(~tbl[5], 2);
    assert_reset();
    checks++;
    if ({digit, digit_vld, illegal, seq_err, err_cnt, tracking} !== '0)
      begin errors++; $display("FAIL midrst_outs got %h want 0",
        {digit, digit_vld, illegal, seq_err, err_cnt, tracking}); end
    release_reset();
    rel = cyc;
    repeat (S + 2) tick();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].cyc != rel + S + 1 ||
        obs_q[0].digit !== 4'd5 || obs_q[0].trk !== 1'b1 ||
        obs_q[0].seq !== 1'b0 || obs_q[0].err !== '0)
      begin errors++; $display("FAIL midrst_reacc got %h want cyc %0d digit 5",
        obs_q.size() ? obs_q[0] : '0, rel + S + 1); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_seq();
    test_bounce();
    test_illegal();
    test_blank();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
